// File: rtl/i2c_tx_sequencer_if.sv
// Handshake bundle between the byte loader, the transmit sequencer and the I2C byte shifter.
// The master side loads bytes and drives the shifter responses; the slave side is the sequencer.
interface i2c_tx_sequencer_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic             start;
    logic [WIDTH-1:0] byte_data;
    logic             byte_valid;
    logic             byte_ack;
    logic             nack;
    logic             busy;
    logic             done;
    logic             abort_err;
    logic [CW-1:0]    count;

    modport master (
        output wr_data, wr_valid, start, byte_ack, nack,
        input  wr_ready, byte_data, byte_valid, busy, done, abort_err, count
    );

    modport slave (
        input  wr_data, wr_valid, start, byte_ack, nack,
        output wr_ready, byte_data, byte_valid, busy, done, abort_err, count
    );
endinterface

// File: rtl/i2c_tx_sequencer.sv
// Buffers up to DEPTH bytes and feeds them one at a time to an I2C byte shifter,
// finishing early with abort_err when the slave NACKs.
module i2c_tx_sequencer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    i2c_tx_sequencer_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CW-1:0]    count_r;
    logic [AW-1:0]    rd_idx_r;
    logic             abort_err_r;

    logic             wr_ready_s;
    logic             wr_fire_s;
    logic [CW-1:0]    count_post_s;
    logic             last_s;
    logic             start_acc_s;
    logic             busy_s;
    logic             done_s;
    logic             byte_valid_s;
    logic [WIDTH-1:0] byte_data_s;

    assign wr_ready_s   = (state_r == IDLE) && (count_r < CW'(DEPTH));
    assign wr_fire_s    = bus.wr_valid && wr_ready_s;
    // A write accepted alongside start already counts toward the transfer length.
    assign count_post_s = count_r + {{(CW-1){1'b0}}, wr_fire_s};
    assign last_s       = (CW'(rd_idx_r) == (count_r - CW'(1'b1)));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and output decode; outputs depend only on registered state.
    always_comb begin
        state_s      = state_r;
        start_acc_s  = 1'b0;
        busy_s       = (state_r != IDLE);
        done_s       = 1'b0;
        byte_valid_s = 1'b0;
        byte_data_s  = {WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (bus.start && (count_post_s != {CW{1'b0}})) begin
                    state_s     = SEND;
                    start_acc_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                byte_valid_s = 1'b1;
                byte_data_s  = mem_r[rd_idx_r];
                if (bus.nack) begin
                    state_s = DONE;
                end else if (bus.byte_ack && last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SEND;
                end
            end
            DONE: begin
                done_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Byte storage; contents survive reset and are only ever overwritten.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire_s) begin
            mem_r[count_r[AW-1:0]] <= bus.wr_data;
        end
    end

    // Fill level, read pointer and sticky NACK flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= {CW{1'b0}};
            rd_idx_r    <= {AW{1'b0}};
            abort_err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    count_r  <= count_post_s;
                    rd_idx_r <= {AW{1'b0}};
                    if (start_acc_s) begin
                        abort_err_r <= 1'b0;
                    end else begin
                        abort_err_r <= abort_err_r;
                    end
                end
                SEND: begin
                    if (bus.nack) begin
                        abort_err_r <= 1'b1;
                    end else if (bus.byte_ack && !last_s) begin
                        rd_idx_r <= rd_idx_r + AW'(1'b1);
                    end else begin
                        rd_idx_r <= rd_idx_r;
                    end
                end
                DONE: begin
                    count_r  <= {CW{1'b0}};
                    rd_idx_r <= {AW{1'b0}};
                end
                default: begin
                    count_r  <= {CW{1'b0}};
                    rd_idx_r <= {AW{1'b0}};
                end
            endcase
        end
    end

    assign bus.wr_ready   = wr_ready_s;
    assign bus.byte_data  = byte_data_s;
    assign bus.byte_valid = byte_valid_s;
    assign bus.busy       = busy_s;
    assign bus.done       = done_s;
    assign bus.abort_err  = abort_err_r;
    assign bus.count      = count_r;
endmodule

// File: tb/tb_i2c_tx_sequencer.sv
// Scenario bench for i2c_tx_sequencer: expected bytes are queued as they are loaded
// and popped as the sequencer presents them to the shifter.
module tb_i2c_tx_sequencer;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   tb_count = 0;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] exp_b;

    i2c_tx_sequencer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    i2c_tx_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_byte(input logic [WIDTH-1:0] b);
        bus.wr_data  = b;
        bus.wr_valid = 1'b1;
        if (tb_count < DEPTH) begin
            exp_q.push_back(b);
            tb_count++;
        end
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hFF;
        bus.start    = 1'b1;
        step();
        bus.wr_valid = 1'b0;
        bus.start    = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_cmp++; if ({bus.done, bus.byte_valid, bus.abort_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {bus.done, bus.byte_valid, bus.abort_err}); end
        n_cmp++; if (bus.byte_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", bus.byte_data); end
        n_cmp++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready: got %b want 1", bus.wr_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int dones;
        write_byte(8'hA0);
        write_byte(8'h12);
        write_byte(8'h34);
        n_cmp++; if (bus.count !== 4'd3) begin n_err++; $display("FAIL basic_count: got %0d want 3", bus.count); end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        tb_count = 0;
        for (int i = 0; i < 3; i++) begin
            exp_b = exp_q.pop_front();
            n_cmp++; if (bus.byte_valid !== 1'b1 || bus.byte_data !== exp_b) begin n_err++; $display("FAIL basic_byte%0d: got v=%b d=%h want v=1 d=%h", i, bus.byte_valid, bus.byte_data, exp_b); end
            step();
            n_cmp++; if (bus.byte_data !== exp_b) begin n_err++; $display("FAIL basic_hold%0d: got %h want %h", i, bus.byte_data, exp_b); end
            bus.byte_ack = 1'b1;
            step();
            bus.byte_ack = 1'b0;
        end
        dones = 0;
        n_cmp++; if (bus.done !== 1'b1 || bus.byte_valid !== 1'b0 || bus.byte_data !== 8'h00) begin n_err++; $display("FAIL basic_done: got done=%b v=%b d=%h want 1 0 00", bus.done, bus.byte_valid, bus.byte_data); end
        for (int i = 0; i < 3; i++) begin
            if (bus.done === 1'b1) dones++;
            step();
        end
        n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL basic_done_pulses: got %0d want 1", dones); end
        n_cmp++; if (bus.count !== 4'd0 || bus.abort_err !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_end: got count=%0d abort=%b busy=%b want 0 0 0", bus.count, bus.abort_err, bus.busy); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) write_byte(8'h10 + 8'(i));
        n_cmp++; if (bus.wr_ready !== 1'b0 || bus.count !== 4'd8) begin n_err++; $display("FAIL full_state: got ready=%b count=%0d want 0 8", bus.wr_ready, bus.count); end
        write_byte(8'hEE);
        n_cmp++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL full_drop: got count=%0d want 8", bus.count); end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        tb_count = 0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_b = exp_q.pop_front();
            n_cmp++; if (bus.byte_valid !== 1'b1 || bus.byte_data !== exp_b) begin n_err++; $display("FAIL full_byte%0d: got v=%b d=%h want v=1 d=%h", i, bus.byte_valid, bus.byte_data, exp_b); end
            bus.byte_ack = 1'b1;
            step();
        end
        bus.byte_ack = 1'b0;
        n_cmp++; if (bus.done !== 1'b1 || bus.byte_valid !== 1'b0) begin n_err++; $display("FAIL full_done: got done=%b v=%b want 1 0", bus.done, bus.byte_valid); end
        step();
        n_cmp++; if (bus.byte_valid !== 1'b0 || exp_q.size() !== 0) begin n_err++; $display("FAIL full_no_ninth: got v=%b left=%0d want 0 0", bus.byte_valid, exp_q.size()); end
    endtask

    task automatic test_nack();
        for (int i = 0; i < 4; i++) write_byte(8'hC0 + 8'(i));
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        tb_count = 0;
        exp_b = exp_q.pop_front();
        n_cmp++; if (bus.byte_data !== exp_b) begin n_err++; $display("FAIL nack_byte0: got %h want %h", bus.byte_data, exp_b); end
        bus.byte_ack = 1'b1;
        step();
        bus.byte_ack = 1'b0;
        exp_b = exp_q.pop_front();
        n_cmp++; if (bus.byte_data !== exp_b) begin n_err++; $display("FAIL nack_byte1: got %h want %h", bus.byte_data, exp_b); end
        bus.nack = 1'b1;
        step();
        bus.nack = 1'b0;
        exp_q.delete();
        n_cmp++; if (bus.done !== 1'b1 || bus.abort_err !== 1'b1 || bus.byte_valid !== 1'b0) begin n_err++; $display("FAIL nack_done: got done=%b abort=%b v=%b want 1 1 0", bus.done, bus.abort_err, bus.byte_valid); end
        step();
        n_cmp++; if (bus.abort_err !== 1'b1 || bus.byte_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL nack_sticky: got abort=%b v=%b busy=%b want 1 0 0", bus.abort_err, bus.byte_valid, bus.busy); end
        write_byte(8'h77);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        tb_count = 0;
        exp_b = exp_q.pop_front();
        n_cmp++; if (bus.abort_err !== 1'b0 || bus.byte_data !== exp_b) begin n_err++; $display("FAIL nack_clear: got abort=%b d=%h want 0 %h", bus.abort_err, bus.byte_data, exp_b); end
        bus.byte_ack = 1'b1;
        step();
        bus.byte_ack = 1'b0;
        step();
    endtask

    task automatic test_empty_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0 || bus.byte_valid !== 1'b0) begin n_err++; $display("FAIL empty_start: got busy=%b v=%b want 0 0", bus.busy, bus.byte_valid); end
        step();
        n_cmp++; if (bus.busy !== 1'b0 || bus.byte_valid !== 1'b0) begin n_err++; $display("FAIL empty_start_late: got busy=%b v=%b want 0 0", bus.busy, bus.byte_valid); end
        bus.start = 1'b1;
        write_byte(8'h55);
        bus.start = 1'b0;
        tb_count = 0;
        exp_b = exp_q.pop_front();
        n_cmp++; if (bus.byte_valid !== 1'b1 || bus.byte_data !== exp_b) begin n_err++; $display("FAIL same_cycle_byte: got v=%b d=%h want 1 %h", bus.byte_valid, bus.byte_data, exp_b); end
        bus.byte_ack = 1'b1;
        step();
        bus.byte_ack = 1'b0;
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL same_cycle_done: got %b want 1", bus.done); end
        step();
    endtask

    task automatic test_rst_mid();
        int dones;
        for (int i = 0; i < 4; i++) write_byte(8'h60 + 8'(i));
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        tb_count = 0;
        for (int i = 0; i < 2; i++) begin
            void'(exp_q.pop_front());
            bus.byte_ack = 1'b1;
            step();
        end
        exp_b = exp_q.pop_front();
        n_cmp++; if (bus.byte_data !== exp_b) begin n_err++; $display("FAIL rst_mid_byte2: got %h want %h", bus.byte_data, exp_b); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.byte_ack = 1'b0;
        exp_q.delete();
        n_cmp++; if (bus.busy !== 1'b0 || bus.count !== 4'd0 || bus.byte_valid !== 1'b0 || bus.done !== 1'b0 || bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid: got busy=%b count=%0d v=%b done=%b ready=%b want 0 0 0 0 1", bus.busy, bus.count, bus.byte_valid, bus.done, bus.wr_ready); end
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.done === 1'b1) dones++;
            step();
        end
        n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL rst_mid_no_done: got %0d want 0", dones); end
    endtask

    task automatic test_ack_nack_last();
        int dones;
        write_byte(8'h81);
        write_byte(8'h82);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        tb_count = 0;
        exp_b = exp_q.pop_front();
        n_cmp++; if (bus.byte_data !== exp_b) begin n_err++; $display("FAIL both_byte0: got %h want %h", bus.byte_data, exp_b); end
        bus.byte_ack = 1'b1;
        step();
        exp_b = exp_q.pop_front();
        n_cmp++; if (bus.byte_data !== exp_b) begin n_err++; $display("FAIL both_byte1: got %h want %h", bus.byte_data, exp_b); end
        bus.nack = 1'b1;
        step();
        bus.byte_ack = 1'b0;
        bus.nack = 1'b0;
        dones = 0;
        n_cmp++; if (bus.abort_err !== 1'b1) begin n_err++; $display("FAIL both_abort: got %b want 1", bus.abort_err); end
        for (int i = 0; i < 4; i++) begin
            if (bus.done === 1'b1) dones++;
            step();
        end
        n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL both_done_pulses: got %0d want 1", dones); end
        n_cmp++; if (bus.abort_err !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL both_end: got abort=%b busy=%b want 1 0", bus.abort_err, bus.busy); end
    endtask

    initial begin
        rst          = 1'b1;
        bus.wr_data  = 8'h00;
        bus.wr_valid = 1'b0;
        bus.start    = 1'b0;
        bus.byte_ack = 1'b0;
        bus.nack     = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_full();
        test_nack();
        test_empty_start();
        test_rst_mid();
        test_ack_nack_last();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
